counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Two-requester round-robin arbiter and sequencer for a shared WIDTH-bit unsigned up/down counter datapath. Each requester issues an add (up) or subtract (dn) operation with its own operand. The block grants one request at a time, latches the winner's operand and direction, applies the operation modulo 2^WIDTH, and returns a one-cycle acknowledge along with the updated count and carry/borrow. It sits between the stimulus/control logic and the counter state, and is the only writer of the count.

## Interface
- WIDTH, 8, operand and count width in bits (unsigned)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  2  request per requester; held high until its ack
- up  in  2  direction per requester: 1 = add operand, 0 = subtract operand
- a0  in  WIDTH  operand of requester 0
- a1  in  WIDTH  operand of requester 1
- clr  in  1  clear count to 0; sampled only in IDLE
- ack  out  2  one-cycle done pulse to the served requester
- q  out  WIDTH  current count
- carry  out  1  carry-out (add) or borrow (subtract) of the last completed operation
- busy  out  1  high in EXEC and DONE
- owner  out  1  index of requester currently or last granted

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE, clr=1:
  - q<=0 and carry<=0.
  - Stay in IDLE. No grant this cycle, even if req is high.
  - Priority pointer unchanged.
- IDLE, clr=0, any req bit high → grant:
  - Only one req high: that requester wins, regardless of the pointer.
  - Both high: the requester named by the priority pointer wins.
  - On grant: latch owner, the winner's up bit and its operand. Pointer <= the other requester. Go to EXEC.
- EXEC:
  - Add: {carry,q} <= {1'b0,q} + operand (WIDTH+1-bit sum). q wraps modulo 2^WIDTH.
  - Subtract: q <= q − operand modulo 2^WIDTH. carry <= 1 iff operand > q.
  - Go to DONE.
- DONE:
  - ack[owner]=1 for exactly this cycle. Then return to IDLE.
- Operand and up changes after grant have no effect on the operation in flight.
- req dropped before grant: ignored, no ack.
- Requester holding req through its ack cycle: serviced again at the next IDLE evaluation, arbitrated normally.
- ack is never asserted for a requester whose req was low when it was granted.
- Reset values:
  - state=IDLE, q=0, carry=0, ack=0, busy=0, owner=0.
  - Priority pointer = requester 0.
- rst mid-operation (EXEC or DONE): abort. No ack pulse, q=0, pointer=0. The next grant follows the reset rules.

## Timing
- Cycle T: IDLE, req sampled at the edge ending T.
- T+1: EXEC, busy=1, owner valid.
- T+2: DONE. q and carry already hold the new values, ack[owner]=1, busy=1.
- T+3: IDLE, busy=0, ack=0. A new request is sampled at the edge ending T+3.
- Latency: 2 cycles from the sampling edge to ack. Throughput: one operation per 3 cycles.
- clr takes effect at the sampling edge: q=0 visible in cycle T+1.
- q and carry change only at the edge ending EXEC, or on clr or rst. They hold otherwise.
- ack is never high in two consecutive cycles.

## Test plan
- Reset release, then req=01, up0=1, a0=5 → ack=01 two cycles after sampling, q=5, carry=0; busy high for exactly 2 cycles.
- From q=250: req=10, up1=1, a1=10 → q=4, carry=1, ack=10, owner=1.
- From q=4: req0 subtract a0=9 → q=251 (0xFB), carry=1. Then req0 subtract a0=251 → q=0, carry=0.
- From q=0, req=11 held, up=11, a0=1, a1=2 → served in order 0,1,0,1; q=1,3,4,6; ack alternates 01,10,01,10; one grant every 3 cycles.
- From q=6: clr=1 with req=11 in IDLE → q=0, carry=0, no grant that cycle. Next cycle (clr=0) the pointer's requester is granted.
- req0 add a0=7 from q=0, rst pulsed during EXEC → no ack, q=0, state IDLE. Then req=11 → requester 0 wins.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Bundle of request, operand and result signals shared between the
// requesters (master side) and the counter arbiter (slave side).
interface counter_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req;
  logic [1:0]       up;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic             clr;
  logic [1:0]       ack;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             busy;
  logic             owner;

  modport master (
    output req, up, a0, a1, clr,
    input  ack, q, carry, busy, owner
  );

  modport slave (
    input  req, up, a0, a1, clr,
    output ack, q, carry, busy, owner
  );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter feeding a shared up/down counter.
// One operation is in flight at a time: IDLE arbitrates, EXEC applies the
// latched operand to the count, DONE pulses ack to the granted requester.
module counter_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  counter_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opnd;
  logic             r_carry;
  logic             r_owner;
  logic             r_ptr;
  logic             r_up;
  logic             w_grant;
  logic             w_winner;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  // Next-state and grant decision; a lone request wins outright, a tie goes to the pointer
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_winner    = r_ptr;
    case (r_state)
      IDLE: begin
        if (!bus.clr && (bus.req != 2'b00)) begin
          w_grant     = 1'b1;
          w_nextState = EXEC;
          if (bus.req == 2'b01) begin
            w_winner = 1'b0;
          end else if (bus.req == 2'b10) begin
            w_winner = 1'b1;
          end else begin
            w_winner = r_ptr;
          end
        end
      end
      EXEC:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Extended-width arithmetic: the top bit is the carry on add and the borrow on subtract
  always_comb begin
    w_sum  = {1'b0, r_q} + {1'b0, r_opnd};
    w_diff = {1'b0, r_q} - {1'b0, r_opnd};
  end

  // State register, grant latching and the count update at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_carry <= 1'b0;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_up    <= 1'b0;
      r_opnd  <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && bus.clr) begin
        r_q     <= '0;
        r_carry <= 1'b0;
      end
      if (w_grant) begin
        r_owner <= w_winner;
        r_ptr   <= ~w_winner;
        r_up    <= bus.up[w_winner];
        r_opnd  <= w_winner ? bus.a1 : bus.a0;
      end
      if (r_state == EXEC) begin
        if (r_up) begin
          r_q     <= w_sum[WIDTH-1:0];
          r_carry <= w_sum[WIDTH];
        end else begin
          r_q     <= w_diff[WIDTH-1:0];
          r_carry <= w_diff[WIDTH];
        end
      end
    end
  end

  // Outputs are decoded straight from registered state so ack lasts exactly the DONE cycle
  always_comb begin
    bus.ack   = 2'b00;
    if (r_state == DONE) begin
      bus.ack = r_owner ? 2'b10 : 2'b01;
    end
    bus.q     = r_q;
    bus.carry = r_carry;
    bus.busy  = (r_state != IDLE);
    bus.owner = r_owner;
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: reset, add/subtract with wrap,
// round-robin alternation under contention, clear priority and abort on reset.
module tb_counter_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  counter_arbiter_if #(.WIDTH(8)) bus ();

  counter_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] reqV, input logic [1:0] upV,
                               input logic [7:0] a0V, input logic [7:0] a1V,
                               input logic clrV);
    bus.req = reqV;
    bus.up  = upV;
    bus.a0  = a0V;
    bus.a1  = a1V;
    bus.clr = clrV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full transaction from an IDLE cycle: request, EXEC, DONE, back to IDLE
  task automatic doOp(input string tag, input logic [1:0] reqV, input logic [1:0] upV,
                      input logic [7:0] a0V, input logic [7:0] a1V,
                      input logic [7:0] expQ, input logic expCarry,
                      input logic [1:0] expAck, input logic expOwner);
    applyStimulus(reqV, upV, a0V, a1V, 1'b0);
    tick();
    checkOutput({tag, ".execBusy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, ".execAck"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, ".execOwner"}, 32'(bus.owner), 32'(expOwner));
    applyStimulus(2'b00, ~upV, 8'hAA, 8'h55, 1'b0);
    bus.req = reqV;
    tick();
    checkOutput({tag, ".doneAck"}, 32'(bus.ack), 32'(expAck));
    checkOutput({tag, ".doneQ"}, 32'(bus.q), 32'(expQ));
    checkOutput({tag, ".doneCarry"}, 32'(bus.carry), 32'(expCarry));
    checkOutput({tag, ".doneBusy"}, 32'(bus.busy), 32'd1);
    bus.req = 2'b00;
    tick();
    checkOutput({tag, ".idleBusy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".idleAck"}, 32'(bus.ack), 32'd0);
    checkOutput({tag, ".idleQ"}, 32'(bus.q), 32'(expQ));
  endtask

  logic [7:0] heldQ     [4] = '{8'd1, 8'd3, 8'd4, 8'd6};
  logic [1:0] heldAck   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       heldOwner [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // Linear directed sequence
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset.q", 32'(bus.q), 32'd0);
    checkOutput("reset.carry", 32'(bus.carry), 32'd0);
    checkOutput("reset.ack", 32'(bus.ack), 32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.owner", 32'(bus.owner), 32'd0);
    rst = 1'b0;
    tick();

    doOp("add5", 2'b01, 2'b01, 8'd5, 8'd0, 8'd5, 1'b0, 2'b01, 1'b0);
    doOp("to250", 2'b01, 2'b01, 8'd245, 8'd0, 8'd250, 1'b0, 2'b01, 1'b0);
    doOp("wrapAdd", 2'b10, 2'b10, 8'd0, 8'd10, 8'd4, 1'b1, 2'b10, 1'b1);
    doOp("borrowSub", 2'b01, 2'b00, 8'd9, 8'd0, 8'd251, 1'b1, 2'b01, 1'b0);
    doOp("exactSub", 2'b01, 2'b00, 8'd251, 8'd0, 8'd0, 1'b0, 2'b01, 1'b0);
    doOp("sub0r1", 2'b10, 2'b00, 8'd0, 8'd0, 8'd0, 1'b0, 2'b10, 1'b1);

    applyStimulus(2'b11, 2'b11, 8'd1, 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("held%0d.owner", i), 32'(bus.owner), 32'(heldOwner[i]));
      checkOutput($sformatf("held%0d.busy", i), 32'(bus.busy), 32'd1);
      tick();
      checkOutput($sformatf("held%0d.ack", i), 32'(bus.ack), 32'(heldAck[i]));
      checkOutput($sformatf("held%0d.q", i), 32'(bus.q), 32'(heldQ[i]));
      if (i == 3) bus.req = 2'b00;
      tick();
      checkOutput($sformatf("held%0d.idleAck", i), 32'(bus.ack), 32'd0);
      checkOutput($sformatf("held%0d.idleBusy", i), 32'(bus.busy), 32'd0);
    end

    applyStimulus(2'b11, 2'b11, 8'd1, 8'd2, 1'b1);
    tick();
    checkOutput("clr.q", 32'(bus.q), 32'd0);
    checkOutput("clr.carry", 32'(bus.carry), 32'd0);
    checkOutput("clr.busy", 32'(bus.busy), 32'd0);
    checkOutput("clr.ack", 32'(bus.ack), 32'd0);
    bus.clr = 1'b0;
    tick();
    checkOutput("afterClr.busy", 32'(bus.busy), 32'd1);
    checkOutput("afterClr.owner", 32'(bus.owner), 32'd0);
    tick();
    checkOutput("afterClr.ack", 32'(bus.ack), 32'd1);
    checkOutput("afterClr.q", 32'(bus.q), 32'd1);
    bus.req = 2'b00;
    tick();

    applyStimulus(2'b00, 2'b00, 8'd0, 8'd0, 1'b1);
    tick();
    checkOutput("preAbort.q", 32'(bus.q), 32'd0);
    applyStimulus(2'b01, 2'b01, 8'd7, 8'd0, 1'b0);
    tick();
    checkOutput("abort.execBusy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.req = 2'b00;
    tick();
    checkOutput("abort.ack", 32'(bus.ack), 32'd0);
    checkOutput("abort.busy", 32'(bus.busy), 32'd0);
    checkOutput("abort.q", 32'(bus.q), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("abort.noLateAck", 32'(bus.ack), 32'd0);
    checkOutput("abort.stillQ", 32'(bus.q), 32'd0);
    applyStimulus(2'b11, 2'b11, 8'd7, 8'd3, 1'b0);
    tick();
    checkOutput("postReset.owner", 32'(bus.owner), 32'd0);
    bus.req = 2'b00;
    tick();
    checkOutput("postReset.ack", 32'(bus.ack), 32'd1);
    checkOutput("postReset.q", 32'(bus.q), 32'd7);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
